// File: rtl/controlador_display_n_dig.sv
// Time-multiplexed N-digit 7-segment driver: hex decode, per-digit points,
// PWM brightness, optional leading-zero blanking and frame-aligned data loads.
module controlador_display_n_dig #(
  parameter int NUM_DIG          = 4,
  parameter int PRESC_BITS       = 16,
  parameter int BRIGHT_BITS      = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [4*NUM_DIG-1:0]   i_Datos,
  input  logic [NUM_DIG-1:0]     i_Punto,
  input  logic                   i_Carga,
  input  logic [BRIGHT_BITS-1:0] i_Brillo,
  input  logic                   i_Blank_Ceros,
  output logic [NUM_DIG-1:0]     o_Anodo,
  output logic [6:0]             o_Segmentos,
  output logic                   o_Punto,
  output logic                   o_Fin_Barrido
);

  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

  // XOR masks that turn active-high internal values into pin polarity;
  // they double as the "everything off" reset values.
  localparam logic [NUM_DIG-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
  localparam logic [6:0]         SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic               PT_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [PRESC_BITS-1:0] cnt;
  logic [IDX_W-1:0]      idx;
  logic                  frame_edge;

  logic [4*NUM_DIG-1:0]  act_datos;
  logic [NUM_DIG-1:0]    act_punto;
  logic [4*NUM_DIG-1:0]  pend_datos;
  logic [NUM_DIG-1:0]    pend_punto;
  logic                  pend_flag;

  logic [3:0]            sel_nib;
  logic                  sel_pt;
  logic                  sel_blank;
  logic [NUM_DIG-1:0]    sel_onehot;
  logic                  zero_run;
  logic [6:0]            seg_hex;
  logic [6:0]            seg_hi;
  logic                  anode_on;
  logic [NUM_DIG-1:0]    an_hi;

  assign frame_edge = (cnt == {PRESC_BITS{1'b1}}) && (idx == IDX_LAST);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == {PRESC_BITS{1'b1}}) begin
        if (idx == IDX_LAST) idx <= '0;
        else                 idx <= idx + 1'b1;
      end
    end
  end

  // A load coinciding with the frame edge bypasses the pending register so
  // the new data is shown in the frame that is just starting.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      act_datos  <= '0;
      act_punto  <= '0;
      pend_datos <= '0;
      pend_punto <= '0;
      pend_flag  <= 1'b0;
    end else if (frame_edge) begin
      if (i_Carga) begin
        act_datos <= i_Datos;
        act_punto <= i_Punto;
        pend_flag <= 1'b0;
      end else if (pend_flag) begin
        act_datos <= pend_datos;
        act_punto <= pend_punto;
        pend_flag <= 1'b0;
      end
    end else if (i_Carga) begin
      pend_datos <= i_Datos;
      pend_punto <= i_Punto;
      pend_flag  <= 1'b1;
    end
  end

  // Walk from the most significant digit down; zero_run stays high while
  // every nibble seen so far is zero, which is exactly the blanking condition.
  always_comb begin
    sel_nib    = 4'h0;
    sel_pt     = 1'b0;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_datos[4*k +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        sel_nib       = act_datos[4*k +: 4];
        sel_pt        = act_punto[k];
        sel_blank     = zero_run && (k != 0);
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_hex = 7'h00;
    case (sel_nib)
      4'h0: seg_hex = 7'h3F;
      4'h1: seg_hex = 7'h06;
      4'h2: seg_hex = 7'h5B;
      4'h3: seg_hex = 7'h4F;
      4'h4: seg_hex = 7'h66;
      4'h5: seg_hex = 7'h6D;
      4'h6: seg_hex = 7'h7D;
      4'h7: seg_hex = 7'h07;
      4'h8: seg_hex = 7'h7F;
      4'h9: seg_hex = 7'h6F;
      4'hA: seg_hex = 7'h77;
      4'hB: seg_hex = 7'h7C;
      4'hC: seg_hex = 7'h39;
      4'hD: seg_hex = 7'h5E;
      4'hE: seg_hex = 7'h79;
      4'hF: seg_hex = 7'h71;
      default: seg_hex = 7'h00;
    endcase
  end

  // cnt == 0 keeps every anode dark for one clock so the previous digit's
  // segments never ghost onto the next digit.
  always_comb begin
    seg_hi   = (i_Blank_Ceros && sel_blank) ? 7'h00 : seg_hex;
    anode_on = (cnt != '0) && (cnt[PRESC_BITS-1 -: BRIGHT_BITS] <= i_Brillo);
    an_hi    = anode_on ? sel_onehot : '0;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Anodo       <= AN_OFF;
      o_Segmentos   <= SEG_OFF;
      o_Punto       <= PT_OFF;
      o_Fin_Barrido <= 1'b0;
    end else begin
      o_Anodo       <= an_hi ^ AN_OFF;
      o_Segmentos   <= seg_hi ^ SEG_OFF;
      o_Punto       <= sel_pt ^ PT_OFF;
      o_Fin_Barrido <= frame_edge;
    end
  end

endmodule

// File: tb/tb_controlador_display_n_dig.sv
// Randomised and directed bench for controlador_display_n_dig against a
// cycle-count based reference model (4 digits, 16-clock slots, 2-bit brightness).
module tb_controlador_display_n_dig;

  logic        i_Clk;
  logic        i_Rst;
  logic [15:0] i_Datos;
  logic [3:0]  i_Punto;
  logic        i_Carga;
  logic [1:0]  i_Brillo;
  logic        i_Blank_Ceros;
  logic [3:0]  o_Anodo;
  logic [6:0]  o_Segmentos;
  logic        o_Punto;
  logic        o_Fin_Barrido;

  controlador_display_n_dig #(
    .NUM_DIG(4), .PRESC_BITS(4), .BRIGHT_BITS(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Datos(i_Datos), .i_Punto(i_Punto),
    .i_Carga(i_Carga), .i_Brillo(i_Brillo), .i_Blank_Ceros(i_Blank_Ceros),
    .o_Anodo(o_Anodo), .o_Segmentos(o_Segmentos), .o_Punto(o_Punto),
    .o_Fin_Barrido(o_Fin_Barrido)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model: elapsed clocks since reset plus the visible/pending data
  int          m_t;
  logic [15:0] m_act_d, m_pend_d;
  logic [3:0]  m_act_p, m_pend_p;
  logic        m_flag;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, m_t);
  endtask

  task automatic model_reset();
    m_t = 0; m_act_d = '0; m_pend_d = '0; m_act_p = '0; m_pend_p = '0; m_flag = 1'b0;
  endtask

  task automatic check_off(input string tag);
    check_val({tag, "_anodo"}, o_Anodo, 4'hF);
    check_val({tag, "_seg"},   o_Segmentos, 7'h7F);
    check_val({tag, "_punto"}, o_Punto, 1'b1);
    check_val({tag, "_fin"},   o_Fin_Barrido, 1'b0);
  endtask

  task automatic step(input logic carga, input logic [15:0] datos, input logic [3:0] punto,
                      input logic [1:0] brillo, input logic blank);
    int c, d;
    logic       on;
    logic [3:0] nib, e_an;
    logic [6:0] e_seg;
    logic       e_pt, e_fin;
    i_Carga = carga; i_Datos = datos; i_Punto = punto; i_Brillo = brillo; i_Blank_Ceros = blank;
    c = m_t % 16;
    d = (m_t / 16) % 4;
    on    = (c != 0) && ((c / 4) <= int'(brillo));
    e_an  = on ? ~(4'b0001 << d) : 4'hF;
    nib   = m_act_d[4*d +: 4];
    if (blank && d > 0 && (m_act_d >> (4*d)) == 16'h0) e_seg = 7'h7F;
    else e_seg = ~seg_tab[nib];
    e_pt  = ~m_act_p[d];
    e_fin = (m_t % 64) == 63;
    @(posedge i_Clk);
    if ((m_t % 64) == 63) begin
      if (carga) begin
        m_act_d = datos; m_act_p = punto; m_flag = 1'b0;
      end else if (m_flag) begin
        m_act_d = m_pend_d; m_act_p = m_pend_p; m_flag = 1'b0;
      end
    end else if (carga) begin
      m_pend_d = datos; m_pend_p = punto; m_flag = 1'b1;
    end
    m_t++;
    #1;
    check_val("anodo", o_Anodo, e_an);
    check_val("segmentos", o_Segmentos, e_seg);
    check_val("punto", o_Punto, e_pt);
    check_val("fin_barrido", o_Fin_Barrido, e_fin);
    i_Carga = 1'b0;
  endtask

  typedef struct {
    logic [15:0] datos;
    logic [3:0]  punto;
    logic [1:0]  brillo;
    logic        blank;
  } dir_t;

  dir_t dir_tab [8] = '{
    '{16'h1234, 4'b0000, 2'd3, 1'b0},
    '{16'h1234, 4'b0000, 2'd0, 1'b0},
    '{16'h1234, 4'b0000, 2'd2, 1'b0},
    '{16'h0050, 4'b0000, 2'd3, 1'b1},
    '{16'h0000, 4'b0000, 2'd3, 1'b1},
    '{16'h0000, 4'b0000, 2'd3, 1'b0},
    '{16'h0050, 4'b0100, 2'd1, 1'b1},
    '{16'h0000, 4'b0100, 2'd3, 1'b1}
  };

  logic [15:0] r_datos;
  logic [3:0]  r_punto;
  logic [1:0]  r_brillo;
  logic        r_blank;
  int          guard;

  initial begin
    i_Rst = 1'b0; i_Carga = 1'b0; i_Datos = '0; i_Punto = '0; i_Brillo = 2'd3; i_Blank_Ceros = 1'b0;
    model_reset();
    #2 i_Rst = 1'b1;
    #1 check_off("rst_init");
    @(posedge i_Clk); @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    model_reset();

    // directed patterns: load, then watch a bit more than two frames
    foreach (dir_tab[j]) begin
      step(1'b1, dir_tab[j].datos, dir_tab[j].punto, dir_tab[j].brillo, dir_tab[j].blank);
      for (int i = 0; i < 140; i++)
        step(1'b0, dir_tab[j].datos, dir_tab[j].punto, dir_tab[j].brillo, dir_tab[j].blank);
    end

    // load while digit 1 is scanning; old digits must persist until the frame edge
    guard = 0;
    while (((m_t % 64) / 16) != 1 && guard < 64) begin
      step(1'b0, 16'h1234, 4'h0, 2'd3, 1'b0); guard++;
    end
    check_val("wait_digit1", ((m_t % 64) / 16), 1);
    step(1'b1, 16'hABCD, 4'b1010, 2'd3, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 16'h0000, 4'h0, 2'd3, 1'b0);

    // load exactly on the frame edge
    guard = 0;
    while ((m_t % 64) != 63 && guard < 64) begin
      step(1'b0, 16'h0000, 4'h0, 2'd3, 1'b0); guard++;
    end
    check_val("wait_frame_edge", m_t % 64, 63);
    step(1'b1, 16'h5A5A, 4'b0001, 2'd3, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b0, 16'h0000, 4'h0, 2'd3, 1'b1);

    // randomised traffic
    r_brillo = 2'd3; r_blank = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r_datos = 16'($urandom) >> (4 * $urandom_range(0, 4));
      r_punto = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r_brillo = 2'($urandom);
      if ($urandom_range(0, 15) == 0) r_blank = ~r_blank;
      step($urandom_range(0, 15) == 0, r_datos, r_punto, r_brillo, r_blank);
    end

    // asynchronous reset in the middle of a slot
    #3 i_Rst = 1'b1;
    #1 check_off("rst_mid");
    @(posedge i_Clk);
    #1 check_off("rst_hold");
    i_Rst = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      r_datos = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 15) == 0, r_datos, 4'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controlador_display_n_dig.md
Name: controlador_display_n_dig

Overview:
Parametrised time-multiplexed driver for an N-digit 7-segment display with hex decode. It adds three features to the fixed 4-digit scanner:
- per-digit decimal points
- PWM brightness control
- optional leading-zero blanking

Data loads are tear-free: new data is staged and applied only at a scan-frame boundary. The block sits between the application datapath and the board's anode and segment pins, and replaces the 4-digit controller in new designs.

Parameters:
NUM_DIG, 4, number of digits scanned (2..8); digit 0 is least significant and rightmost.
PRESC_BITS, 16, digit slot length = 2^PRESC_BITS clocks; must be >= BRIGHT_BITS+1.
BRIGHT_BITS, 4, width of the brightness control.
ANODE_ACTIVE_LOW, 1, 1 means an anode is on when driven 0.
SEG_ACTIVE_LOW, 1, 1 means a segment or point is lit when driven 0.

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset, asynchronous, active-high
i_Datos  in  4*NUM_DIG  hex nibbles; digit k = i_Datos[4k+3:4k]
i_Punto  in  NUM_DIG  decimal point per digit, 1 = lit; sampled together with i_Datos
i_Carga  in  1  load strobe; captures i_Datos and i_Punto
i_Brillo  in  BRIGHT_BITS  brightness; 0 = minimum, all-ones = maximum
i_Blank_Ceros  in  1  1 = blank leading zeros; live input, not staged
o_Anodo  out  NUM_DIG  digit enables; bit k drives digit k
o_Segmentos  out  7  segments {g,f,e,d,c,b,a}
o_Punto  out  1  decimal point of the active digit
o_Fin_Barrido  out  1  one-cycle pulse marking the start of a new frame

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - slot counter cnt = 0, digit index idx = 0
  - active and pending registers = 0, pending flag = 0
  - o_Anodo: all anodes off
  - o_Segmentos and o_Punto: off
  - o_Fin_Barrido = 0
- Scanning:
  - cnt increments every clock and wraps from 2^PRESC_BITS-1 to 0.
  - On wrap, idx increments; from NUM_DIG-1 it wraps to 0. That edge is the frame edge.
  - One frame lasts NUM_DIG*2^PRESC_BITS clocks.
- Staging (tear-free load):
  - i_Carga=1 on a non-frame edge: pending <= {i_Datos, i_Punto}, flag <= 1. A later load overwrites pending.
  - On a frame edge: if i_Carga=1, active <= the inputs directly and flag <= 0. Else if flag=1, active <= pending and flag <= 0. Else active is unchanged.
- Decode: standard hex 0-F, active-high forms:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - If SEG_ACTIVE_LOW=1, segments and point are inverted at the output.
- Leading-zero blanking:
  - Applies only when i_Blank_Ceros=1.
  - Digit k (k>0) is blanked when its nibble and every higher digit's nibble are 0. Blanked means segments off.
  - Digit 0 is never blanked.
  - Decimal points are unaffected by blanking.
- Anode enable for digit idx:
  - On iff cnt != 0 AND cnt[PRESC_BITS-1 -: BRIGHT_BITS] <= i_Brillo.
  - cnt == 0 is a ghost-blanking cycle: all anodes are off.
  - Non-selected digits are always off.
  - Duty cycle ≈ (i_Brillo+1)/2^BRIGHT_BITS.
- Latency:
  - o_Anodo, o_Segmentos and o_Punto are registered from the current idx, cnt and active register, so they lag by 1 clock.
  - o_Fin_Barrido = 1 for exactly the clock after a frame edge; it is also registered.
- Changes to i_Brillo and i_Blank_Ceros take effect on the next clock, with no staging.

Test Plan:
Bench configuration: NUM_DIG=4, PRESC_BITS=4, BRIGHT_BITS=2, both polarities active-low.
1. Reset: assert i_Rst mid-slot -> same cycle o_Anodo=4'b1111, o_Segmentos=7'b1111111, o_Punto=1, o_Fin_Barrido=0. Release -> first digit-0 anode low at the output 2 clocks later (cnt=1, plus one register stage).
2. Load: pulse i_Carga with i_Datos=16'h1234, i_Brillo=3 -> after the next o_Fin_Barrido:
   - digit 0 slot: o_Anodo=4'b1110, o_Segmentos=7'b0011001 ('4') on slot cycles 1..15, 4'b1111 on cycle 0
   - digit 3 shows '1' = 7'b1111001
3. Brightness: i_Brillo=0 -> anode on only at cnt 1..3 (3 of 16 clocks per slot). i_Brillo=2 -> cnt 1..11.
4. Blanking: i_Datos=16'h0050, i_Blank_Ceros=1 -> digits 3 and 2 show 7'b1111111, digit 1 '5' = 7'b0010010, digit 0 '0' = 7'b1000000. With 16'h0000 -> only digit 0 shows '0'. With i_Blank_Ceros=0 -> all show '0'.
5. Tear-free:
   - Load 16'hABCD while digit 1 is active -> digits 1..3 keep the old values until the frame edge.
   - o_Fin_Barrido pulses every 64 clocks.
   - i_Carga on the frame edge itself -> the new data appears in that same frame.
6. Points: i_Punto=4'b0100 -> o_Punto=0 only during the digit-2 slot, and still lit when digit 2 is blanked.
